// File: rtl/loop_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loop_buffer_pkg
//  Description : Shared types, opcode constants and helpers for the
//                loop_buffer_ctrl loop-capture/replay block.
//  Revision    : 1.0 - initial release
// ============================================================================
package loop_buffer_pkg;

  // Controller states: follow fetch, record the body, one-cycle prefetch, replay
  typedef enum logic [1:0] {
    TRACK   = 2'd0,
    CAPTURE = 2'd1,
    WAIT    = 2'd2,
    REPLAY  = 2'd3
  } state_t;

  // RISC-V major opcodes that end or redirect a basic block
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // True for a B-type branch or JAL; only the opcode field is inspected
  function automatic logic is_ctrl(input logic [6:0] instr);
    return (instr == OPC_BRANCH) || (instr == OPC_JAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/loop_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : loop_buffer_ram
//  Description : DEPTH x DATA_W simple dual-port storage for the loop body.
//                One write port, one registered read port with read enable;
//                read data holds while the read enable is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_buffer_ram
  import loop_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: record one captured instruction per enabled cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: one-cycle latency, data held while rd_en is low
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/loop_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : loop_buffer_ctrl
//  Description : Detects a short backward branch/JAL, captures the loop body
//                on the next iteration and replays it to decode while fetch
//                is blocked. Exits with a one-cycle flush to tail+4.
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_buffer_ctrl
  import loop_buffer_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 64,
  parameter int MAX_LOOP_BYTES = 4 * DEPTH,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  input  logic [DATA_W-1:0] fetch_instr,
  input  logic [31:0]       branch_imm,
  input  logic              stall,
  input  logic              mispredict,
  output logic              block_fetch,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [CNT_W-1:0]  loop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;
  // The default MAX_LOOP_BYTES (4*DEPTH) would admit a body one entry larger
  // than the buffer, so the accepted span is clamped to what actually fits.
  localparam int          LIMIT_BYTES = (MAX_LOOP_BYTES < 4 * (DEPTH - 1)) ?
                                        MAX_LOOP_BYTES : 4 * (DEPTH - 1);
  localparam logic [31:0] LIMIT       = 32'(LIMIT_BYTES);

  state_t            state;
  state_t            state_next;
  logic [31:0]       head;
  logic [31:0]       tail;
  logic [31:0]       next_pc;
  logic [LEN_W-1:0]  len;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              started;
  logic [CNT_W-1:0]  count;

  logic [31:0]       neg_imm;
  logic              fetch_ctrl;
  logic              candidate;
  logic              exit_req;
  logic              wrap;
  logic              latch_cand;
  logic              cap_write;
  logic              cap_done;
  logic              rd_adv;
  logic [DATA_W-1:0] ram_rdata;

  assign neg_imm    = -branch_imm;
  assign fetch_ctrl = is_ctrl(fetch_instr[6:0]);
  assign candidate  = enable & fetch_valid & ~mispredict & fetch_ctrl &
                      branch_imm[31] & (neg_imm <= LIMIT);
  assign exit_req   = mispredict | ~enable;
  assign wrap       = ({1'b0, rd_idx} == (len - LEN_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TRACK;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, datapath strobes and Moore/flush outputs
  always_comb begin
    state_next  = state;
    latch_cand  = 1'b0;
    cap_write   = 1'b0;
    cap_done    = 1'b0;
    rd_adv      = 1'b0;
    block_fetch = 1'b0;
    out_valid   = 1'b0;
    flush       = 1'b0;
    case (state)
      TRACK: begin
        if (candidate) begin
          latch_cand = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (exit_req) begin
          state_next = TRACK;
        end else if (fetch_valid) begin
          if (!started) begin
            // Before the head arrives, unrelated fetches are ignored
            if (fetch_pc == head) begin
              if (fetch_ctrl && (fetch_pc != tail)) begin
                state_next = TRACK;
              end else begin
                cap_write = 1'b1;
              end
            end
          end else if ((fetch_pc != next_pc) ||
                       (fetch_ctrl && (fetch_pc != tail))) begin
            state_next = TRACK;
          end else begin
            cap_write = 1'b1;
          end
          if (cap_write && (fetch_pc == tail)) begin
            cap_done   = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        block_fetch = 1'b1;
        if (exit_req) begin
          state_next = TRACK;
        end else begin
          // Prefetch entry 0 so REPLAY has data on its first cycle
          rd_adv     = 1'b1;
          state_next = REPLAY;
        end
      end
      REPLAY: begin
        block_fetch = 1'b1;
        out_valid   = 1'b1;
        if (exit_req) begin
          flush      = ~reset;
          state_next = TRACK;
        end else if (!stall) begin
          rd_adv = 1'b1;
        end
      end
      default: begin
        state_next = TRACK;
      end
    endcase
  end

  // Loop bounds, capture/replay pointers and the iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      next_pc <= '0;
      len     <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      started <= 1'b0;
      count   <= '0;
    end else begin
      if (latch_cand) begin
        head    <= fetch_pc + branch_imm;
        tail    <= fetch_pc;
        len     <= LEN_W'(neg_imm >> 2) + LEN_W'(1);
        wr_idx  <= '0;
        started <= 1'b0;
      end
      if (cap_write) begin
        wr_idx  <= wr_idx + AW'(1);
        next_pc <= fetch_pc + 32'd4;
        started <= 1'b1;
      end
      if (cap_done) begin
        rd_idx <= '0;
        count  <= '0;
      end
      if (rd_adv) begin
        rd_idx <= wrap ? '0 : rd_idx + AW'(1);
        if (wrap && (count != '1)) begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  loop_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (cap_write),
    .wr_addr (wr_idx),
    .wr_data (fetch_instr),
    .rd_en   (rd_adv),
    .rd_addr (rd_idx),
    .rd_data (ram_rdata)
  );

  // Stale buffer contents never leak out: data is qualified by out_valid
  assign out_instr   = out_valid ? ram_rdata : '0;
  assign redirect_pc = flush ? (tail + 32'd4) : '0;
  assign loop_count  = count;

endmodule
`default_nettype wire
